// File: rtl/dram_pkg.sv
// Shared encodings for the DRAM burst responder: command codes, burst geometry
// and the controller state enum.
package dram_pkg;

    typedef enum logic {
        DRAM_RD = 1'b0,
        DRAM_WR = 1'b1
    } dram_cmd_e;

    localparam int BEATS      = 8;
    localparam int LINE_BYTES = 64;
    localparam int BEAT_W     = 3;
    localparam int DATA_W     = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } dram_state_e;

    // Word index of one beat inside the backing store: line in the upper bits, beat below.
    function automatic logic [31:0] word_index(input logic [31:0] line, input logic [BEAT_W-1:0] beat);
        return (line << BEAT_W) | {29'd0, beat};
    endfunction

endpackage

// File: rtl/dram_word_mem.sv
// Single-port 64-bit word store: combinational read, synchronous write, never reset
// so contents survive a responder reset.
module dram_word_mem
    import dram_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: one beat per enabled edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/dram_burst_responder.sv
// DRAM-side burst responder: accepts one line request, waits LATENCY cycles, then
// moves 8 beats over a shared bidirectional bus and pulses done.
module dram_burst_responder
    import dram_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_LINES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        cmd,
    input  logic [31:0] addr,
    inout  wire  [63:0] data,
    output logic        strobe,
    output logic        busy,
    output logic        done
);

    localparam int         LINE_W    = $clog2(MEM_LINES);
    localparam int         WORD_W    = LINE_W + BEAT_W;
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    dram_state_e          state_q,  state_d;
    dram_cmd_e            cmd_q,    cmd_d;
    logic [LINE_W-1:0]    line_q,   line_d;
    logic [3:0]           wait_q,   wait_d;
    logic [BEAT_W-1:0]    beat_q,   beat_d;
    logic                 strobe_q, strobe_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    logic [WORD_W-1:0]    word_addr_s;
    logic [DATA_W-1:0]    rdata_s;
    logic                 mem_we_s;
    logic                 rd_oe_s;
    logic                 addr_unused_s;

    // Offset within the line and address bits above the memory size are don't-care.
    assign addr_unused_s = ^{addr[31:6+LINE_W], addr[5:0]};

    // Next-state logic for the request/wait/burst/done sequence.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        line_d   = line_q;
        wait_d   = wait_q;
        beat_d   = beat_q;
        strobe_d = strobe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WAIT;
                    cmd_d   = dram_cmd_e'(cmd);
                    line_d  = addr[6 +: LINE_W];
                    wait_d  = WAIT_INIT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d  = ST_BURST;
                    beat_d   = 3'd0;
                    strobe_d = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_BURST: begin
                // The beat counter only wraps on the way out of the burst.
                if (beat_q == 3'd7) begin
                    state_d  = ST_DONE;
                    beat_d   = 3'd0;
                    strobe_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                wait_d   = 4'd0;
                beat_d   = 3'd0;
                strobe_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= DRAM_RD;
            line_q   <= '0;
            wait_q   <= 4'd0;
            beat_q   <= 3'd0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            line_q   <= line_d;
            wait_q   <= wait_d;
            beat_q   <= beat_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign word_addr_s = WORD_W'(word_index(32'(line_q), beat_q));
    assign mem_we_s    = (state_q == ST_BURST) && (cmd_q == DRAM_WR);
    // Bus is owned only while presenting read beats; reset drops state and so the drive.
    assign rd_oe_s     = (state_q == ST_BURST) && (cmd_q == DRAM_RD);
    assign data        = rd_oe_s ? rdata_s : {DATA_W{1'bz}};

    assign strobe = strobe_q;
    assign busy   = busy_q;
    assign done   = done_q;

    dram_word_mem #(
        .DEPTH  (MEM_LINES * BEATS),
        .ADDR_W (WORD_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .addr  (word_addr_s),
        .wdata (data),
        .rdata (rdata_s)
    );

endmodule

// File: tb/tb_dram_burst_responder.sv
// Randomised scoreboard bench for dram_burst_responder against a line-array reference model.
module tb_dram_burst_responder;
    import dram_pkg::*;

    localparam int LAT   = 4;
    localparam int LINES = 128;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        req    = 1'b0;
    logic        cmd    = 1'b0;
    logic [31:0] addr   = 32'h0;
    wire  [63:0] data;
    logic        tb_drv = 1'b1;
    logic [63:0] tb_val = 64'h0;
    logic        strobe;
    logic        busy;
    logic        done;

    assign data = tb_drv ? tb_val : {64{1'bz}};

    dram_burst_responder #(.LATENCY(LAT), .MEM_LINES(LINES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .cmd    (cmd),
        .addr   (addr),
        .data   (data),
        .strobe (strobe),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int          c;
        logic        rd;
        logic [63:0] d;
    } beat_t;

    beat_t       beat_q[$];
    int          done_q[$];
    logic [63:0] model [LINES*8];
    beat_t       mon_b;
    int          mon_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'(a[12:6]);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a beat or done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_strobe", {63'd0, strobe}, 64'd0);
            check("reset_busy",   {63'd0, busy},   64'd0);
            check("reset_done",   {63'd0, done},   64'd0);
            if (tb_drv) check("reset_bus", data, tb_val);
        end else begin
            if (strobe) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_strobe", {63'd0, strobe}, 64'd0);
                end else begin
                    mon_b = beat_q.pop_front();
                    check("strobe_cycle", 64'(cyc), 64'(mon_b.c));
                    check("busy_in_burst", {63'd0, busy}, 64'd1);
                    if (mon_b.rd) check("read_beat", data, mon_b.d);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(mon_d));
                    check("busy_with_done", {63'd0, busy}, 64'd0);
                end
            end
            if (tb_drv) check("bus_owner", data, tb_val);
        end
    end

    task automatic start(input logic c, input logic [31:0] a, input logic [63:0] b0, output int e0);
        @(posedge clk); #1;
        req = 1'b1; cmd = c; addr = a;
        if (c) begin tb_drv = 1'b1; tb_val = b0; end
        else   tb_drv = 1'b0;
        @(posedge clk); #1;
        e0 = cyc;
        req = 1'b0; cmd = 1'($urandom); addr = $urandom;
    endtask

    task automatic gap();
        @(posedge clk); #1;
        tb_drv = 1'b1; tb_val = 64'h0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic use_base, input logic [63:0] base, input int abort);
        logic [63:0] w [8];
        int e0, k, guard, ln;
        logic s, seen;
        for (int i = 0; i < 8; i++) w[i] = use_base ? base + 64'(i) : {$urandom, $urandom};
        ln = line_of(a);
        start(1'b1, a, w[0], e0);
        for (int i = 0; i < 8; i++) begin
            if (abort < 0 || i < abort) begin
                beat_q.push_back('{e0 + LAT + i, 1'b0, 64'h0});
                model[ln*8 + i] = w[i];
            end
        end
        if (abort < 0) done_q.push_back(e0 + LAT + 8);
        k = 0; guard = 0;
        while (k < 8 && guard < 40) begin
            @(negedge clk); s = strobe;
            @(posedge clk); #1;
            guard++;
            if (s) begin
                k++;
                if (k < 8) tb_val = w[k];
                else       tb_val = 64'h0;
                if (k == abort) begin
                    rst_n = 1'b0;
                    #1;
                    check("abort_strobe", {63'd0, strobe}, 64'd0);
                    check("abort_busy",   {63'd0, busy},   64'd0);
                    check("abort_bus",    data, tb_val);
                    beat_q.delete();
                    done_q.delete();
                    @(posedge clk); @(posedge clk); #1;
                    rst_n = 1'b1;
                    return;
                end
            end
        end
        if (k < 8) check("write_timeout", 64'(k), 64'd8);
        seen = 1'b0; guard = 0;
        while (!seen && guard < 20) begin
            @(negedge clk);
            seen = done;
            guard++;
        end
        if (!seen) check("write_done_timeout", {63'd0, seen}, 64'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic poke);
        int e0, ln, guard;
        logic seen;
        ln = line_of(a);
        start(1'b0, a, 64'h0, e0);
        for (int i = 0; i < 8; i++) beat_q.push_back('{e0 + LAT + i, 1'b1, model[ln*8 + i]});
        done_q.push_back(e0 + LAT + 8);
        if (poke) begin
            // Second request while busy, aimed at a different line; must be ignored.
            @(posedge clk); #1;
            req = 1'b1; cmd = 1'($urandom); addr = a ^ 32'h0000_1FC0;
            @(posedge clk); #1;
            req = 1'b0;
        end
        seen = 1'b0; guard = 0;
        while (!seen && guard < LAT + 30) begin
            @(negedge clk);
            seen = done;
            guard++;
        end
        if (!seen) check("read_done_timeout", {63'd0, seen}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int ab;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int l = 0; l < LINES; l++) begin
            a = ($urandom & ~32'h0000_1FC0) | (32'(l) << 6);
            do_write(a, 1'b0, 64'h0, -1);
        end

        do_write(32'h0000_0040, 1'b1, 64'h1111_1111_1111_1111, -1);
        do_read (32'h0000_0040, 1'b0);

        do_write(32'h0000_2040, 1'b1, 64'hA5A5_0000_5A5A_0000, -1);
        do_read (32'h0000_0040, 1'b0);
        do_read (32'h0000_007F, 1'b0);

        do_read (32'h0000_0040, 1'b1);

        do_write(32'h0000_0040, 1'b1, 64'hDEAD_BEEF_0000_0000, 3);
        gap();
        do_read (32'h0000_0040, 1'b0);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : -1;
                do_write(a, 1'b0, 64'h0, ab);
            end else begin
                do_read(a, $urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 2) == 0) gap();
        end

        gap();
        repeat (5) @(posedge clk);
        check("beats_outstanding", 64'(beat_q.size()), 64'd0);
        check("dones_outstanding", 64'(done_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
